prog_ram_arbiter: RTL
=====================

Name: prog_ram_arbiter

Overview:
- Shares one single-port 16x1024 RAM (ram_rw_16x1024) between two requesters.
- Requester 0 is processor instruction fetch (pc / ram_read_en of simple_proc_data_proc).
- Requester 1 is a host/debug port that loads program images and peeks/pokes memory at run time.
- Arbitrates one access per cycle with round-robin fairness and routes read data back to the owning requester with the RAM's fixed read latency.

Parameters:
- ADDR_W, 10, RAM address width (1024 words).
- DATA_W, 16, RAM word width.
- RD_LAT, 1, cycles from a granted read to valid RAM dout; legal range 1..4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- r0_req  in  1  fetch request, held until granted.
- r0_addr  in  ADDR_W  fetch address.
- r0_gnt  out  1  fetch access accepted this cycle.
- r0_rvalid  out  1  r0_rdata valid.
- r0_rdata  out  DATA_W  fetch read data.
- r1_req  in  1  host request, held until granted.
- r1_we  in  1  host write (1) / read (0).
- r1_addr  in  ADDR_W  host address.
- r1_wdata  in  DATA_W  host write data.
- r1_gnt  out  1  host access accepted this cycle.
- r1_rvalid  out  1  r1_rdata valid (reads only).
- r1_rdata  out  DATA_W  host read data.
- ram_read_en  out  1  to RAM read_en.
- ram_write_en  out  1  to RAM write_en.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_din  out  DATA_W  to RAM din.
- ram_dout  in  DATA_W  from RAM dout.

Behaviour:
- Reset (async assert, sync release):
  - All gnt, rvalid, ram_read_en and ram_write_en = 0; rdata, ram_addr and ram_din = 0.
  - last_owner pointer = 1, so r0 wins the first tie.
  - Return pipeline cleared.
- Grant logic is combinational from req plus registered last_owner:
  - Only one requester asserts req → it is granted.
  - Both assert req → grant goes to the requester that is not last_owner.
  - At most one gnt per cycle.
  - last_owner updates on the clock edge after any grant.
- RAM drive:
  - Driven combinationally in the grant cycle.
  - ram_read_en = gnt & ~we (r0 is always a read).
  - ram_write_en = r1_gnt & r1_we.
  - ram_addr and ram_din are muxed from the winner.
  - No grant → enables 0, addr/din hold their previous value (registered hold mux).
- Handshake:
  - Request is accepted in the cycle where req & gnt.
  - Requester may change addr/we/wdata or drop req the next cycle.
  - Dropping req before gnt is legal and issues no access.
- Read return:
  - RD_LAT-deep shift register of {valid, owner}.
  - rX_rvalid pulses exactly RD_LAT cycles after the read grant.
  - rX_rdata = ram_dout, registered with rvalid and held until the next rvalid for that requester.
  - Back-to-back grants yield back-to-back rvalids, in order.
- Writes produce no rvalid.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM write-first ordering is the requirement).
- Throughput: 1 access/cycle; with both requesting continuously, grants alternate r0,r1,r0,...
- Reset mid-operation: in-flight reads are discarded; no rvalid after reset deasserts for reads granted before reset.

Optional Feature:
- Macro: PROG_RAM_ARB_STATS_EN.
- When defined, adds the following outputs:
  - r0_gnt_cnt (16) and r1_gnt_cnt (16): saturating at 16'hFFFF.
  - r0_wait_max (8): longest consecutive cycles r0_req was high without gnt, saturating at 255.
  - stats_clr (in 1): synchronous clear of all three.
  - All three reset to 0.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package prog_ram_arb_pkg holds:
  - owner_t enum (OWN_R0=0, OWN_R1=1)
  - localparam RD_LAT_MAX=4
  - return-slot struct {valid, owner}
- One natural sub-module: prog_ram_rd_return, the RD_LAT shift pipeline and rdata steering.

Test Plan:
- Reset then r0_req=1, r0_addr=10'h005, RAM[5]=16'h3c00 → r0_gnt same cycle, ram_read_en=1, r0_rvalid=1 with r0_rdata=16'h3c00 exactly RD_LAT cycles later; r1 outputs stay 0.
- Both req high for 6 cycles (r1 reads) → gnt sequence r0,r1,r0,r1,r0,r1 and rvalid sequence identical, delayed RD_LAT.
- r1 write addr 10'h010 data 16'hBEEF, next cycle r0 reads 10'h010 → ram_write_en then ram_read_en; r0_rdata=16'hBEEF.
- r1 loads 64 words 0..63 (data=addr^16'hA5A5) with r0 idle, then r0 fetches all 64 → every r0_rdata matches; no r1_rvalid ever.
- Assert reset one cycle after an r0 read grant with RD_LAT=2 → no r0_rvalid after release; all outputs 0 during reset.
- With PROG_RAM_ARB_STATS_EN, 10 r0 grants and 3 r1 grants, r0 starved 1 cycle max → r0_gnt_cnt=10, r1_gnt_cnt=3, r0_wait_max=1; stats_clr → all 0.

Source files
------------

// File: rtl/prog_ram_arb_pkg.sv
// rtl/prog_ram_arb_pkg.sv - shared owner encoding and read-return slot type for prog_ram_arbiter
package prog_ram_arb_pkg;

    typedef enum logic {
        OWN_R0 = 1'b0,
        OWN_R1 = 1'b1
    } owner_t;

    localparam int RD_LAT_MAX = 4;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_slot_t;

endpackage

// File: rtl/prog_ram_arbiter_if.sv
// rtl/prog_ram_arbiter_if.sv - requester/RAM bundle for prog_ram_arbiter; stats signals under PROG_RAM_ARB_STATS_EN
interface prog_ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              r0_req;
    logic [ADDR_W-1:0] r0_addr;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic              ram_read_en;
    logic              ram_write_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

`ifdef PROG_RAM_ARB_STATS_EN
    logic              stats_clr;
    logic [15:0]       r0_gnt_cnt;
    logic [15:0]       r1_gnt_cnt;
    logic [7:0]        r0_wait_max;
`endif

    modport slave (
        input  r0_req, r0_addr, r1_req, r1_we, r1_addr, r1_wdata, ram_dout,
        output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
        output ram_read_en, ram_write_en, ram_addr, ram_din
`ifdef PROG_RAM_ARB_STATS_EN
        , input stats_clr
        , output r0_gnt_cnt, r1_gnt_cnt, r0_wait_max
`endif
    );

    modport master (
        output r0_req, r0_addr, r1_req, r1_we, r1_addr, r1_wdata, ram_dout,
        input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
        input  ram_read_en, ram_write_en, ram_addr, ram_din
`ifdef PROG_RAM_ARB_STATS_EN
        , output stats_clr
        , input r0_gnt_cnt, r1_gnt_cnt, r0_wait_max
`endif
    );

endinterface

// File: rtl/prog_ram_rd_return.sv
// rtl/prog_ram_rd_return.sv - RD_LAT-deep {valid, owner} pipeline steering RAM dout to the owning requester
module prog_ram_rd_return
    import prog_ram_arb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  owner_t            issue_owner,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata
);
    localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

    rd_slot_t          pipe [LAT];
    logic [DATA_W-1:0] r0_hold;
    logic [DATA_W-1:0] r1_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                pipe[i] <= '{valid: 1'b0, owner: OWN_R0};
            end
            r0_hold <= '0;
            r1_hold <= '0;
        end else begin
            pipe[0] <= '{valid: issue_valid, owner: issue_owner};
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (r0_rvalid) r0_hold <= ram_dout;
            if (r1_rvalid) r1_hold <= ram_dout;
        end
    end

    // dout is only valid in the return cycle, so rdata bypasses the hold register there
    assign r0_rvalid = pipe[LAT-1].valid && (pipe[LAT-1].owner == OWN_R0);
    assign r1_rvalid = pipe[LAT-1].valid && (pipe[LAT-1].owner == OWN_R1);
    assign r0_rdata  = r0_rvalid ? ram_dout : r0_hold;
    assign r1_rdata  = r1_rvalid ? ram_dout : r1_hold;

endmodule

// File: rtl/prog_ram_arbiter.sv
// rtl/prog_ram_arbiter.sv - round-robin fetch/host arbiter for one single-port RAM; optional stats via PROG_RAM_ARB_STATS_EN
module prog_ram_arbiter
    import prog_ram_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input logic               clk,
    input logic               reset,
    prog_ram_arbiter_if.slave bus
);
    owner_t            last_owner;
    logic              gnt0;
    logic              gnt1;
    logic              rd_en;
    logic              wr_en;
    owner_t            issue_owner;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] din_c;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] din_hold;

    // grants are gated by reset so nothing reaches the RAM while reset is asserted
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (bus.r0_req && (!bus.r1_req || last_owner == OWN_R1)) begin
                gnt0 = 1'b1;
            end else if (bus.r1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign rd_en       = gnt0 || (gnt1 && !bus.r1_we);
    assign wr_en       = gnt1 && bus.r1_we;
    assign issue_owner = gnt1 ? OWN_R1 : OWN_R0;
    assign addr_c      = gnt0 ? bus.r0_addr : (gnt1 ? bus.r1_addr : addr_hold);
    assign din_c       = gnt1 ? bus.r1_wdata : din_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= OWN_R1;
            addr_hold  <= '0;
            din_hold   <= '0;
        end else begin
            if (gnt0) begin
                last_owner <= OWN_R0;
            end else if (gnt1) begin
                last_owner <= OWN_R1;
            end
            addr_hold <= addr_c;
            din_hold  <= din_c;
        end
    end

    assign bus.r0_gnt       = gnt0;
    assign bus.r1_gnt       = gnt1;
    assign bus.ram_read_en  = rd_en;
    assign bus.ram_write_en = wr_en;
    assign bus.ram_addr     = addr_c;
    assign bus.ram_din      = din_c;

    prog_ram_rd_return #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_return (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (rd_en),
        .issue_owner (issue_owner),
        .ram_dout    (bus.ram_dout),
        .r0_rvalid   (bus.r0_rvalid),
        .r0_rdata    (bus.r0_rdata),
        .r1_rvalid   (bus.r1_rvalid),
        .r1_rdata    (bus.r1_rdata)
    );

`ifdef PROG_RAM_ARB_STATS_EN
    logic [15:0] r0_cnt;
    logic [15:0] r1_cnt;
    logic [7:0]  wait_cur;
    logic [7:0]  wait_max;
    logic [7:0]  wait_next;

    assign wait_next = (bus.r0_req && !gnt0)
                     ? ((wait_cur == 8'hFF) ? 8'hFF : wait_cur + 8'd1)
                     : 8'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r0_cnt   <= '0;
            r1_cnt   <= '0;
            wait_cur <= '0;
            wait_max <= '0;
        end else if (bus.stats_clr) begin
            r0_cnt   <= '0;
            r1_cnt   <= '0;
            wait_cur <= '0;
            wait_max <= '0;
        end else begin
            if (gnt0 && r0_cnt != 16'hFFFF) r0_cnt <= r0_cnt + 16'd1;
            if (gnt1 && r1_cnt != 16'hFFFF) r1_cnt <= r1_cnt + 16'd1;
            wait_cur <= wait_next;
            if (wait_next > wait_max) wait_max <= wait_next;
        end
    end

    assign bus.r0_gnt_cnt  = r0_cnt;
    assign bus.r1_gnt_cnt  = r1_cnt;
    assign bus.r0_wait_max = wait_max;
`endif

endmodule
